// File: rtl/n64_joybus_reader_if.sv
// Controller-side bundle for the Joybus frame reader: arm/abort level, raw line,
// decoded word and status flags.
interface n64_joybus_reader_if #(
    parameter int NUM_BITS = 32
);
    logic                enable;
    logic                gpio_line;
    logic [NUM_BITS-1:0] con_data;
    logic                data_valid;
    logic                error;
    logic                busy;

    modport master (output enable, gpio_line, input con_data, data_valid, error, busy);
    modport slave  (input enable, gpio_line, output con_data, data_valid, error, busy);
endinterface

// File: rtl/n64_joybus_reader.sv
// Joybus controller response decoder: mid-bit sampling of NUM_BITS data bits plus stop bit.
// Define N64_GLITCH_FILTER_EN to insert a 3-sample majority filter after the synchroniser.
module n64_joybus_reader #(
    parameter int CYCLES_PER_US = 50,
    parameter int NUM_BITS      = 32,
    parameter int TIMEOUT_US    = 100,
    parameter int LOW_MAX_US    = 4
) (
    input logic                clock,
    input logic                reset,
    n64_joybus_reader_if.slave bus
);
    localparam int SAMPLE = 2 * CYCLES_PER_US;
    localparam int TMO    = TIMEOUT_US * CYCLES_PER_US;
    localparam int LMAX   = LOW_MAX_US * CYCLES_PER_US;
    localparam int TBIG   = (TMO > LMAX) ? ((TMO > SAMPLE) ? TMO : SAMPLE)
                                         : ((LMAX > SAMPLE) ? LMAX : SAMPLE);
    localparam int TW     = $clog2(TBIG) + 1;
    localparam int BW     = $clog2(NUM_BITS + 1);

    // Limits are compared one cycle early so the state change lands on the cycle the limit is reached.
    localparam logic [TW-1:0] SAMPLE_T  = TW'(SAMPLE);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TMO - 1);
    localparam logic [TW-1:0] LMAX_LAST = TW'(LMAX - 1);
    localparam logic [BW-1:0] NBITS_T   = BW'(NUM_BITS);

    typedef enum logic [2:0] {
        IDLE, WAIT_EDGE, MEASURE, WAIT_HIGH, STOP, DONE, ERROR
    } state_t;

    state_t              state_q, state_d;
    logic                sync1_q, sync2_q, prev_q, prev_d, en_prev_q;
    logic [TW-1:0]       timer_q, timer_d;
    logic [BW-1:0]       bits_q, bits_d;
    logic [NUM_BITS-1:0] shift_q, shift_d, con_data_q, con_data_d;
    logic                stop_low_q, stop_low_d;
    logic                data_valid_q, data_valid_d, error_q, error_d, busy_q, busy_d;
    logic                line, fall;

`ifdef N64_GLITCH_FILTER_EN
    logic hist1_q, hist2_q, filt_q, filt_d;

    assign filt_d = (sync2_q & hist1_q) | (sync2_q & hist2_q) | (hist1_q & hist2_q);
    assign line   = filt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hist1_q <= 1'b1;
            hist2_q <= 1'b1;
            filt_q  <= 1'b1;
        end else begin
            hist1_q <= sync2_q;
            hist2_q <= hist1_q;
            filt_q  <= filt_d;
        end
    end
`else
    assign line = sync2_q;
`endif

    assign prev_d = line;
    assign fall   = prev_q & ~line;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q + TW'(1);
        bits_d       = bits_q;
        shift_d      = shift_q;
        stop_low_d   = stop_low_q;
        con_data_d   = con_data_q;
        data_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                // Arm only on an enable rising edge so one enable pulse yields at most one frame.
                if (bus.enable && !en_prev_q) begin
                    state_d    = WAIT_EDGE;
                    bits_d     = '0;
                    shift_d    = '0;
                    stop_low_d = 1'b0;
                end
            end
            WAIT_EDGE: begin
                if (timer_q == TMO_LAST) state_d = ERROR;
                else if (fall) begin
                    state_d = MEASURE;
                    timer_d = TW'(1);
                end
            end
            MEASURE: begin
                if (timer_q == SAMPLE_T) begin
                    shift_d = {shift_q[NUM_BITS-2:0], line};
                    bits_d  = bits_q + BW'(1);
                    state_d = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (line) begin
                    timer_d    = '0;
                    stop_low_d = 1'b0;
                    state_d    = (bits_q == NBITS_T) ? STOP : WAIT_EDGE;
                end else if (timer_q == LMAX_LAST) state_d = ERROR;
            end
            STOP: begin
                if (!stop_low_q) begin
                    if (timer_q == TMO_LAST) state_d = ERROR;
                    else if (fall) begin
                        stop_low_d = 1'b1;
                        timer_d    = TW'(1);
                    end
                end else if (prev_q) begin
                    // Completion is taken from the edge-detect stage, one cycle behind the level.
                    con_data_d   = shift_q;
                    data_valid_d = 1'b1;
                    state_d      = DONE;
                end else if (timer_q == LMAX_LAST) state_d = ERROR;
            end
            default: timer_d = timer_q;
        endcase
        if (!bus.enable) begin
            state_d      = IDLE;
            con_data_d   = con_data_q;
            data_valid_d = 1'b0;
        end
        busy_d  = (state_d != IDLE) && (state_d != DONE);
        error_d = (state_d == ERROR);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            prev_q       <= 1'b1;
            en_prev_q    <= 1'b1;
            state_q      <= IDLE;
            timer_q      <= '0;
            bits_q       <= '0;
            shift_q      <= '0;
            stop_low_q   <= 1'b0;
            con_data_q   <= '0;
            data_valid_q <= 1'b0;
            error_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            sync1_q      <= bus.gpio_line;
            sync2_q      <= sync1_q;
            prev_q       <= prev_d;
            en_prev_q    <= bus.enable;
            state_q      <= state_d;
            timer_q      <= timer_d;
            bits_q       <= bits_d;
            shift_q      <= shift_d;
            stop_low_q   <= stop_low_d;
            con_data_q   <= con_data_d;
            data_valid_q <= data_valid_d;
            error_q      <= error_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.con_data   = con_data_q;
    assign bus.data_valid = data_valid_q;
    assign bus.error      = error_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_n64_joybus_reader.sv
// Directed + randomized bench for n64_joybus_reader; expected words come from the
// frame content itself, timing from the microsecond rules of the Joybus encoding.
module tb_n64_joybus_reader;
    localparam int US   = 50;
    localparam int NB   = 32;
    localparam int TMO  = 100 * US;
    localparam int LMAX = 4 * US;
`ifdef N64_GLITCH_FILTER_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 4;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;

    n64_joybus_reader_if #(.NUM_BITS(NB)) bus ();

    n64_joybus_reader #(
        .CYCLES_PER_US(US), .NUM_BITS(NB), .TIMEOUT_US(100), .LOW_MAX_US(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int   cyc = 0, dv_cnt = 0, dv_cyc = 0, rise_cyc = 0;
    logic dv_busy = 1'b0, dv_pbusy = 1'b0, busy_p = 1'b0;
    int   errors = 0, checks = 0;
    logic [NB-1:0] model_data;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        busy_p <= bus.busy;
        if (bus.data_valid) begin
            dv_cnt   <= dv_cnt + 1;
            dv_cyc   <= cyc;
            dv_busy  <= bus.busy;
            dv_pbusy <= busy_p;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // 1 = 1us low / 3us high, 0 = 3us low / 1us high
    task automatic send_bit(input logic b);
        bus.gpio_line = 1'b0;
        tick(b ? US : 3 * US);
        bus.gpio_line = 1'b1;
        tick(b ? 3 * US : US);
    endtask

    task automatic send_bits(input logic [NB-1:0] w, input int n);
        for (int i = NB - 1; i >= NB - n; i--) send_bit(w[i]);
    endtask

    task automatic send_stop();
        bus.gpio_line = 1'b0;
        tick(2 * US);
        bus.gpio_line = 1'b1;
        rise_cyc = cyc;
        tick(LAT + 4);
    endtask

    task automatic arm();
        bus.enable = 1'b0;
        tick(3);
        bus.enable = 1'b1;
        tick(US);
    endtask

    task automatic frame_ok(input string tag, input logic [NB-1:0] w);
        int n0;
        n0 = dv_cnt;
        send_bits(w, NB);
        send_stop();
        model_data = w;
        chk({tag, "_dv_count"}, 64'(dv_cnt - n0), 64'd1);
        chk({tag, "_data"}, 64'(bus.con_data), 64'(model_data));
        chk({tag, "_latency"}, 64'(dv_cyc - rise_cyc), 64'(LAT));
        chk({tag, "_busy_at_dv"}, 64'(dv_busy), 64'd0);
        chk({tag, "_busy_before_dv"}, 64'(dv_pbusy), 64'd1);
        chk({tag, "_error"}, 64'(bus.error), 64'd0);
    endtask

    initial begin
        logic [NB-1:0] w;
        int n0;
        bus.enable    = 1'b0;
        bus.gpio_line = 1'b1;
        tick(5);
        chk("rst_con_data", 64'(bus.con_data), 64'd0);
        chk("rst_data_valid", 64'(bus.data_valid), 64'd0);
        chk("rst_error", 64'(bus.error), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        reset = 1'b0;
        model_data = '0;
        tick(3);

        arm();
        frame_ok("t1", 32'hA5C3_0F81);

        // idle-high timeout: WAIT_EDGE is entered one cycle after enable rises
        bus.enable = 1'b0;
        tick(3);
        bus.enable = 1'b1;
        tick(TMO);
        chk("t2_no_error_before_tmo", 64'(bus.error), 64'd0);
        tick(1);
        chk("t2_error_at_tmo", 64'(bus.error), 64'd1);
        chk("t2_con_data_kept", 64'(bus.con_data), 64'(model_data));
        bus.enable = 1'b0;
        tick(1);
        chk("t2_error_cleared", 64'(bus.error), 64'd0);
        chk("t2_busy_cleared", 64'(bus.busy), 64'd0);

        // bit 7 held low 5us
        arm();
        n0 = dv_cnt;
        w  = $urandom;
        send_bits(w, 7);
        bus.gpio_line = 1'b0;
        tick(3 * US);
        chk("t3_no_error_at_3us_low", 64'(bus.error), 64'd0);
        tick(2 * US);
        chk("t3_error_at_5us_low", 64'(bus.error), 64'd1);
        bus.gpio_line = 1'b1;
        tick(US);
        chk("t3_no_dv", 64'(dv_cnt - n0), 64'd0);
        chk("t3_con_data_kept", 64'(bus.con_data), 64'(model_data));
        bus.enable = 1'b0;
        tick(2);

        // abort after 12 ones, then a frame that would expose leftover bits
        arm();
        send_bits(32'hFFFF_FFFF, 12);
        bus.enable = 1'b0;
        tick(1);
        chk("t4_busy_after_abort", 64'(bus.busy), 64'd0);
        tick(5);
        arm();
        frame_ok("t4", 32'h0000_0001);

        // asynchronous reset in the middle of bit 20
        arm();
        send_bits($urandom, 20);
        bus.gpio_line = 1'b0;
        tick(10);
        #3 reset = 1'b1;
        #1;
        model_data = '0;
        chk("t5_rst_con_data", 64'(bus.con_data), 64'd0);
        chk("t5_rst_data_valid", 64'(bus.data_valid), 64'd0);
        chk("t5_rst_error", 64'(bus.error), 64'd0);
        chk("t5_rst_busy", 64'(bus.busy), 64'd0);
        bus.gpio_line = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(5);
        n0 = dv_cnt;
        send_bits($urandom, NB);
        send_stop();
        chk("t5_not_armed_dv", 64'(dv_cnt - n0), 64'd0);
        chk("t5_not_armed_data", 64'(bus.con_data), 64'(model_data));
        chk("t5_not_armed_busy", 64'(bus.busy), 64'd0);
        arm();
        frame_ok("t5_rearmed", $urandom);

        for (int k = 0; k < 2; k++) begin
            arm();
            frame_ok($sformatf("rand%0d", k), $urandom);
        end

`ifdef N64_GLITCH_FILTER_EN
        arm();
        bus.gpio_line = 1'b0;
        tick(1);
        bus.gpio_line = 1'b1;
        tick(US);
        chk("t6_busy_after_glitch", 64'(bus.busy), 64'd1);
        frame_ok("t6", 32'hFFFF_0000);
`endif

        bus.enable = 1'b0;
        tick(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
